// File: rtl/circular_shift_engine_if.sv
// Valid/ready request/response bundle for circular_shift_engine.
// The engine connects through the slave modport, the producer/consumer
// side through the master modport. AW is derived from N exactly as the
// engine derives it, so both ends agree on the amount width.
interface circular_shift_engine_if #(
    parameter int N = 8
);
    localparam int AW = $clog2(N) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [AW-1:0] in_amt;
    logic          in_dir;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          busy;

    modport master (
        output in_valid, in_data, in_amt, in_dir, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_dir, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/circular_shift_engine.sv
// circular_shift_engine: sequential runtime-programmable rotator.
// A request (word, amount, direction) is accepted in IDLE, rotated one bit
// per clock in ROT, and held in DONE until the consumer takes it.
// Optional macro CIRC_SHIFT_MOD_REDUCE_EN: reduce the amount modulo N at
// the accept edge so rotations of N or more do not waste cycles. The
// result word is the same either way; only latency changes.
module circular_shift_engine #(
    parameter int N = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    circular_shift_engine_if.slave  bus
);
    localparam int AW = $clog2(N) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ROT  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [N-1:0]  r_data;
    logic [AW-1:0] r_cnt;
    logic          r_dir;

    logic          w_accept;
    logic          w_release;
    logic [AW-1:0] w_eff_amt;
    logic [N-1:0]  w_rot;

    assign w_accept  = bus.in_valid  && (r_state == S_IDLE);
    assign w_release = bus.out_ready && (r_state == S_DONE);

`ifdef CIRC_SHIFT_MOD_REDUCE_EN
    // A rotation by a multiple of N is the identity, so only the remainder
    // needs to be walked through.
    assign w_eff_amt = AW'(bus.in_amt % AW'(N));
`else
    assign w_eff_amt = bus.in_amt;
`endif

    // One-position rotation of the held word in the latched direction.
    always_comb begin
        w_rot = r_dir ? {r_data[0], r_data[N-1:1]}
                      : {r_data[N-2:0], r_data[N-1]};
    end

    // Handshake outputs are pure functions of state so neither ready nor
    // valid ever combinationally follows the opposite side.
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_data  = r_data;

    // Control FSM together with the datapath registers it steers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_data  <= bus.in_data;
                        r_dir   <= bus.in_dir;
                        r_cnt   <= w_eff_amt;
                        r_state <= (w_eff_amt != '0) ? S_ROT : S_DONE;
                    end
                end
                S_ROT: begin
                    r_data <= w_rot;
                    r_cnt  <= r_cnt - AW'(1);
                    if (r_cnt == AW'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (w_release) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_circular_shift_engine.sv
// Self-checking bench for circular_shift_engine (N = 8).
// Directed scenarios plus randomized transactions, each checked against a
// reference rotation computed by shifting a doubled copy of the word.
module tb_circular_shift_engine;
    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    circular_shift_engine_if #(.N(N)) bus ();

    circular_shift_engine #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference rotation: take the right window of the word concatenated
    // with itself after shifting by (amt mod N).
    function automatic logic [7:0] ref_rot(logic [7:0] d, int amt, logic dir);
        int          s;
        logic [15:0] t;
        s = amt % N;
        if (!dir) begin
            t = {d, d} << s;
            return t[15:8];
        end else begin
            t = {d, d} >> s;
            return t[7:0];
        end
    endfunction

    // Expected number of rotation cycles for a requested amount.
    function automatic int ref_lat(int amt);
`ifdef CIRC_SHIFT_MOD_REDUCE_EN
        return amt % N;
`else
        return amt;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the engine idle; returns just after the accept edge.
    task automatic accept(input logic [7:0] d, input logic [3:0] a, input logic dir);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_dir   = dir;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        // Scramble inputs: they must have no effect after the accept edge.
        bus.in_data  = 8'($urandom);
        bus.in_amt   = 4'($urandom);
        bus.in_dir   = 1'($urandom);
    endtask

    // Waits for out_valid counting cycles after the accept edge; ends at a negedge.
    task automatic wait_result(input logic [7:0] exp_data, input int exp_lat);
        int cyc;
        cyc = 0;
        for (;;) begin
            @(negedge clk);
            if (bus.out_valid) break;
            chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
            cyc++;
            if (cyc > 40) begin
                chk("timeout_out_valid", 32'(bus.out_valid), 32'd1);
                return;
            end
        end
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("out_data", 32'(bus.out_data), 32'(exp_data));
        chk("busy_done", 32'(bus.busy), 32'd1);
        chk("in_ready_done", 32'(bus.in_ready), 32'd0);
    endtask

    // Holds out_ready low for a number of cycles, checking the result stays put.
    task automatic hold_result(input logic [7:0] exp_data, input int hold);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_out_data", 32'(bus.out_data), 32'(exp_data));
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
    endtask

    // Output handshake from a negedge in DONE; ends at the following negedge.
    task automatic handshake();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
        chk("post_hs_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic run_txn(input logic [7:0] d, input logic [3:0] a, input logic dir,
                           input int hold, input logic [7:0] exp_data);
        accept(d, a, dir);
        wait_result(exp_data, ref_lat(int'(a)));
        hold_result(exp_data, hold);
        $display("[TB] txn data=%b amt=%0d dir=%0d hold=%0d -> out=%b", d, a, dir, hold, bus.out_data);
        handshake();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [3:0] a;
        logic       dir;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_dir    = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state, during and after reset.
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

        // Directed rotations from the plan.
        run_txn(8'b10110101, 4'd3, 1'b0, 0, 8'b10101101);
        run_txn(8'b10110101, 4'd3, 1'b1, 0, 8'b10110110);
        run_txn(8'b00100110, 4'd11, 1'b0, 0, 8'b00110001);
        run_txn(8'b01011010, 4'd8, 1'b1, 0, 8'b01011010);

        // Zero amount with out_ready held high: in_ready drops for one cycle only.
        bus.out_ready = 1'b1;
        accept(8'b01100110, 4'd0, 1'b0);
        @(negedge clk);
        chk("zero_out_valid", 32'(bus.out_valid), 32'd1);
        chk("zero_out_data", 32'(bus.out_data), 32'h66);
        chk("zero_in_ready_low", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("zero_in_ready_back", 32'(bus.in_ready), 32'd1);
        chk("zero_out_valid_gone", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
        $display("[TB] txn data=01100110 amt=0 dir=0 zero-amount with out_ready high");

        // Backpressure with a competing request presented during DONE.
        accept(8'b10110101, 4'd2, 1'b1);
        wait_result(ref_rot(8'b10110101, 2, 1'b1), ref_lat(2));
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h3C;
        bus.in_amt   = 4'd1;
        bus.in_dir   = 1'b0;
        hold_result(ref_rot(8'b10110101, 2, 1'b1), 5);
        $display("[TB] txn data=10110101 amt=2 dir=1 backpressure 5 cycles -> out=%b", bus.out_data);
        handshake();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        wait_result(ref_rot(8'h3C, 1, 1'b0), ref_lat(1));
        $display("[TB] txn data=00111100 amt=1 dir=0 pending request -> out=%b", bus.out_data);
        handshake();

        // Reset mid-rotation discards the transaction.
        accept(8'b11100000, 4'd7, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_out_data", 32'(bus.out_data), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("midrst_no_stale", 32'(bus.out_valid), 32'd0);
        end
        $display("[TB] txn data=11100000 amt=7 dir=0 reset mid-rotation, discarded");

        // Randomized transactions against the reference model.
        for (int i = 0; i < 25; i++) begin
            d   = 8'($urandom);
            a   = 4'($urandom_range(0, 15));
            dir = 1'($urandom);
            run_txn(d, a, dir, int'($urandom_range(0, 3)), ref_rot(d, int'(a), dir));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
